// File: rtl/hash_table_arbiter.sv
// Round-robin front end that shares one hash-table port among NUM_REQ requesters.
// Requests issue one at a time; responses return in issue order, routed by an ID FIFO.
module hash_table_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 2,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         tbl_data_o,
    output logic                          tbl_valid_o,
    input  logic                          tbl_ready_i,
    input  logic [DATA_WIDTH-1:0]         tbl_data_i,
    input  logic                          tbl_valid_i,
    output logic                          tbl_ready_o,
    output logic [$clog2(TAG_DEPTH):0]    outstanding_o,
    output logic                          err_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [DATA_WIDTH-1:0] r_tbl_data;
    logic [IDX_W-1:0]      r_fifo [TAG_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_err;

    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_win_inc;
    int                    w_best;
    int                    w_dist;
    logic                  w_start;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [IDX_W-1:0]      w_head;

    // Winner is the valid requester at the smallest rotational distance from r_rr_ptr.
    always_comb begin
        w_win  = r_rr_ptr;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
            if (req_valid_i[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = IDX_W'(k);
            end
        end
        w_win_inc = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A full FIFO blocks new grants on the occupancy before any same-cycle pop.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_push       = 1'b0;
        tbl_valid_o  = 1'b0;
        req_ready_o  = '0;
        case (r_state)
            IDLE: begin
                if ((|req_valid_i) && (int'(r_count) < TAG_DEPTH)) begin
                    w_start      = 1'b1;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                tbl_valid_o          = 1'b1;
                req_ready_o[r_grant] = tbl_ready_i;
                if (tbl_ready_i) begin
                    w_push       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The granted word is captured so a requester dropping valid cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_tbl_data <= '0;
        end else if (w_start) begin
            r_grant    <= w_win;
            r_rr_ptr   <= w_win_inc;
            r_tbl_data <= req_data_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (tbl_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Response path is purely combinational; an orphan response is drained and flagged.
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_pop       = tbl_valid_i && !w_empty && rsp_ready_i[w_head];
    assign tbl_ready_o = !reset && (w_empty || rsp_ready_i[w_head]);
    assign rsp_data_o  = tbl_data_i;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
        assign rsp_valid_o[gi] = !reset && !w_empty && tbl_valid_i && (w_head == IDX_W'(gi));
    end

    assign tbl_data_o    = r_tbl_data;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Randomized scoreboard bench for hash_table_arbiter with a queue-based reference model
// of round-robin issue, in-order response routing and the orphan-response error flag.
`timescale 1ns/1ps
module tb_hash_table_arbiter;
    localparam int DW = 64;
    localparam int NR = 2;
    localparam int TD = 8;
    localparam logic [DW-1:0] KEY = 64'hA5A5_5A5A_0F0F_F0F0;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NR*DW-1:0]   req_data_i = '0;
    logic [NR-1:0]      req_valid_i = '0;
    logic [NR-1:0]      req_ready_o;
    logic [DW-1:0]      rsp_data_o;
    logic [NR-1:0]      rsp_valid_o;
    logic [NR-1:0]      rsp_ready_i = '0;
    logic [DW-1:0]      tbl_data_o;
    logic               tbl_valid_o;
    logic               tbl_ready_i = 1'b0;
    logic [DW-1:0]      tbl_data_i = '0;
    logic               tbl_valid_i = 1'b0;
    logic               tbl_ready_o;
    logic [$clog2(TD):0] outstanding_o;
    logic               err_o;

    hash_table_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
        .clk(clk), .reset(reset),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .tbl_data_o(tbl_data_o), .tbl_valid_o(tbl_valid_o), .tbl_ready_i(tbl_ready_i),
        .tbl_data_i(tbl_data_i), .tbl_valid_i(tbl_valid_i), .tbl_ready_o(tbl_ready_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        int          id;
        logic [DW-1:0] word;
    } ent_t;

    // Scoreboard queues (expected DUT outputs) and reference-model state.
    ent_t          exp_tbl[$];
    ent_t          exp_rsp[$];
    logic [DW-1:0] rq [NR][$];
    logic [DW-1:0] tq[$];
    int            m_ids[$];
    bit            m_busy = 0;
    int            m_win = 0;
    int            m_last = NR - 1;
    bit            m_err = 0;
    int            n_xfer = 0;

    int p_rv = 0, p_tready = 0, p_tvalid = 0, p_rready = 0;
    bit spur = 0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Stimulus: requesters, table responder and response consumers, driven on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) begin
                if (rq[k].size() > 0) begin
                    req_valid_i[k] = (m_busy && m_win == k) || ($urandom_range(99) < p_rv);
                    req_data_i[k*DW +: DW] = rq[k][0];
                end else begin
                    req_valid_i[k] = 1'b0;
                    req_data_i[k*DW +: DW] = '0;
                end
                rsp_ready_i[k] = ($urandom_range(99) < p_rready);
            end
            tbl_ready_i = ($urandom_range(99) < p_tready);
            if (tq.size() > 0) begin
                tbl_valid_i = ($urandom_range(99) < p_tvalid) || spur;
                tbl_data_i  = tq[0] ^ KEY;
            end else begin
                tbl_valid_i = spur;
                tbl_data_i  = {$urandom, $urandom};
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues and model status.
    initial begin
        int id;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (tbl_valid_o) begin
                    if (exp_tbl.size() == 0) begin
                        check("tbl_valid_unexpected", tbl_valid_o, 0);
                    end else begin
                        id = exp_tbl[0].id;
                        check("tbl_data", tbl_data_o, exp_tbl[0].word);
                        check("req_ready", req_ready_o, tbl_ready_i ? (1 << id) : 0);
                        if (tbl_ready_i) begin
                            $display("issue: req=%0d data=%h", id, tbl_data_o);
                            void'(exp_tbl.pop_front());
                        end
                    end
                end else begin
                    check("tbl_valid", tbl_valid_o, exp_tbl.size() != 0);
                    check("req_ready_idle", req_ready_o, 0);
                end

                if (tbl_valid_i) begin
                    if (exp_rsp.size() == 0) begin
                        check("orphan_rsp_valid", rsp_valid_o, 0);
                        check("orphan_tbl_ready", tbl_ready_o, 1);
                    end else begin
                        id = exp_rsp[0].id;
                        check("rsp_valid", rsp_valid_o, 1 << id);
                        check("rsp_data", rsp_data_o, exp_rsp[0].word);
                        check("tbl_ready", tbl_ready_o, rsp_ready_i[id]);
                        if (rsp_ready_i[id]) begin
                            $display("return: req=%0d data=%h", id, rsp_data_o);
                            void'(exp_rsp.pop_front());
                        end
                    end
                end else begin
                    check("rsp_valid_idle", rsp_valid_o, 0);
                end

                check("outstanding", outstanding_o, m_ids.size());
                check("err", err_o, m_err);
            end
        end
    end

    // Reference model: advances by the rules of one rising edge using the inputs just driven.
    initial begin
        int   sz;
        bit   pop;
        bit   found;
        int   k;
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                sz  = m_ids.size();
                pop = tbl_valid_i && (sz > 0) && rsp_ready_i[m_ids[0]];
                if (tbl_valid_i && sz == 0) m_err = 1;
                if (tbl_valid_i && tbl_ready_o && tq.size() > 0) void'(tq.pop_front());
                if (m_busy) begin
                    if (tbl_ready_i) begin
                        m_ids.push_back(m_win);
                        e.id = m_win;
                        e.word = rq[m_win][0] ^ KEY;
                        exp_rsp.push_back(e);
                        tq.push_back(tbl_data_o);
                        void'(rq[m_win].pop_front());
                        m_busy = 0;
                        n_xfer++;
                    end
                end else if (req_valid_i != '0 && sz < TD) begin
                    found = 0;
                    for (int i = 1; i <= NR; i++) begin
                        k = (m_last + i) % NR;
                        if (!found && req_valid_i[k]) begin
                            found = 1;
                            m_win = k;
                        end
                    end
                    m_busy = 1;
                    m_last = m_win;
                    e.id = m_win;
                    e.word = rq[m_win][0];
                    exp_tbl.push_back(e);
                end
                if (pop) void'(m_ids.pop_front());
            end
        end
    end

    task automatic load(input int k, input int n);
        for (int i = 0; i < n; i++) rq[k].push_back({$urandom, $urandom});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        total++;
        while ((rq[0].size() + rq[1].size() + m_ids.size() + tq.size()) != 0 || m_busy) begin
            cycles(1);
            n++;
            if (n > budget) begin
                bad++;
                $display("FAIL %s: not drained after %0d cycles", name, budget);
                return;
            end
        end
    endtask

    initial begin
        int   x0;
        int   n;
        logic [DW-1:0] d0;

        #4;
        check("rst_tbl_valid", tbl_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_tbl_ready", tbl_ready_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_err", err_o, 0);
        cycles(2);
        reset = 1'b0;

        // Contention: both requesters always valid, table always ready.
        p_rv = 100; p_tready = 100; p_tvalid = 100; p_rready = 100;
        load(0, 12);
        load(1, 12);
        cycles(6);
        x0 = n_xfer;
        cycles(20);
        check("xfer_rate_20cyc", n_xfer - x0, 10);
        wait_drain("contention_drain", 200);

        // Back-pressure: single grant to requester 1 held while the table stalls.
        p_tready = 0;
        load(1, 1);
        n = 0;
        while (!tbl_valid_o && n < 20) begin cycles(1); n++; end
        check("bp_grant_seen", tbl_valid_o, 1);
        d0 = tbl_data_o;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check("bp_valid_held", tbl_valid_o, 1);
            check("bp_data_stable", tbl_data_o, d0);
            check("bp_req_ready", req_ready_o, 0);
        end
        p_tready = 100;
        wait_drain("bp_drain", 100);

        // Randomized traffic with back-pressure on every interface.
        p_rv = 60; p_tready = 70; p_tvalid = 60; p_rready = 70;
        load(0, 30);
        load(1, 30);
        wait_drain("random_drain", 3000);

        // FIFO full: no responses, so issue stops at TD outstanding.
        p_rv = 100; p_tready = 100; p_tvalid = 0;
        load(0, 6);
        load(1, 6);
        cycles(40);
        check("full_outstanding", outstanding_o, TD);
        check("full_no_grant", tbl_valid_o, 0);
        p_tvalid = 100; p_rready = 100;
        wait_drain("full_drain", 300);

        // Orphan response with nothing outstanding.
        spur = 1;
        cycles(1);
        spur = 0;
        cycles(2);
        check("orphan_err_sticky", err_o, 1);

        // Asynchronous reset while granted with three IDs queued.
        p_tvalid = 0; p_tready = 100;
        load(0, 4);
        n = 0;
        while (m_ids.size() < 3 && n < 50) begin cycles(1); n++; end
        p_tready = 0;
        n = 0;
        while (!(tbl_valid_o && outstanding_o == 3) && n < 20) begin cycles(1); n++; end
        check("pre_reset_outstanding", outstanding_o, 3);
        reset = 1'b1;
        m_ids.delete(); exp_tbl.delete(); exp_rsp.delete();
        for (int k = 0; k < NR; k++) rq[k].delete();
        m_busy = 0; m_last = NR - 1; m_err = 0;
        #1;
        check("arst_tbl_valid", tbl_valid_o, 0);
        check("arst_req_ready", req_ready_o, 0);
        check("arst_rsp_valid", rsp_valid_o, 0);
        check("arst_tbl_ready", tbl_ready_o, 0);
        check("arst_outstanding", outstanding_o, 0);
        check("arst_err", err_o, 0);
        cycles(2);
        reset = 1'b0;

        // Responses to the discarded requests arrive after reset and flag an error.
        p_tvalid = 100; p_tready = 100; p_rready = 100;
        wait_drain("stale_drain", 50);
        cycles(2);
        check("stale_err", err_o, 1);

        // Short random tail starting from the post-reset round-robin state.
        p_rv = 70; p_tready = 60; p_tvalid = 70; p_rready = 60;
        load(0, 10);
        load(1, 10);
        wait_drain("tail_drain", 1000);
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(20 * 40000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hash_table_arbiter.md
HASH_TABLE_ARBITER -- requirements
Module: hash_table_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the width of request and response words.
REQ-002 SHALL have parameter NUM_REQ, default 2, the number of requesters, legal range 2..4.
REQ-003 SHALL have parameter TAG_DEPTH, default 8, the depth of the in-flight ID FIFO, a power of two.
REQ-004 SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
REQ-005 SHALL have these requester-side ports:
- req_data_i  in  NUM_REQ*DATA_WIDTH  request words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_valid_i  in  NUM_REQ  request valid, one bit per requester.
- req_ready_o  out  NUM_REQ  request accepted, one bit per requester.
- rsp_data_o  out  DATA_WIDTH  response word, shared by all requesters.
- rsp_valid_o  out  NUM_REQ  response valid, one-hot.
- rsp_ready_i  in  NUM_REQ  requester can take a response.
REQ-006 SHALL have these table-side ports:
- tbl_data_o  out  DATA_WIDTH  word to hash_table data_in.
- tbl_valid_o  out  1  to hash_table valid_i.
- tbl_ready_i  in  1  from hash_table ready_o.
- tbl_data_i  in  DATA_WIDTH  from hash_table read_data_o.
- tbl_valid_i  in  1  from hash_table valid_o.
- tbl_ready_o  out  1  to hash_table ready_i.
REQ-007 SHALL have these status ports:
- outstanding_o  out  $clog2(TAG_DEPTH)+1  current ID FIFO occupancy.
- err_o  out  1  sticky protocol-error flag.

Function
REQ-008 A transfer on any valid/ready pair SHALL occur on a rising clk edge where both signals are 1.
REQ-009 Arbitration SHALL be round-robin. Priority SHALL start at the requester after the last granted one. After reset, requester 0 has highest priority.
REQ-010 The grant SHALL be registered and held until tbl_valid_o && tbl_ready_i. It SHALL NOT switch while tbl_valid_o=1 and the transfer is still pending.
REQ-011 The issue FSM SHALL have two states:
- IDLE: tbl_valid_o=0.
- IDLE -> GRANT when some req_valid_i=1 and outstanding_o < TAG_DEPTH. The arbiter selects the winner on this edge.
- GRANT: tbl_valid_o=1; tbl_data_o = the winner's word; req_ready_o[winner] = tbl_ready_i; all other req_ready_o=0.
- GRANT -> IDLE on the transfer.
REQ-012 On each table-side accept, the winner's index SHALL be pushed into the ID FIFO.
REQ-013 No new grant SHALL be issued while outstanding_o == TAG_DEPTH. This holds even if a pop occurs in the same cycle.
REQ-014 Responses SHALL return in request order. Routing SHALL use the head of the ID FIFO:
- rsp_valid_o[head] = tbl_valid_i; all other rsp_valid_o bits = 0.
- tbl_ready_o = rsp_ready_i[head].
- rsp_data_o = tbl_data_i.
REQ-015 The ID FIFO SHALL pop on tbl_valid_i && tbl_ready_o.
REQ-016 A push and a pop in the same cycle SHALL leave outstanding_o unchanged. The FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-017 If tbl_valid_i=1 while the FIFO is empty:
- all rsp_valid_o = 0.
- tbl_ready_o = 1, so the word is drained and dropped.
- err_o SHALL set and stay 1 until reset.
REQ-018 The path from request to response SHALL add zero cycles of latency beyond one cycle of grant registration. The response path SHALL be combinational.
REQ-019 A requester that drops req_valid_i while granted SHALL have no effect. tbl_valid_o stays 1 until accepted, and the stalled word is the registered one.

Reset
REQ-020 While reset=1, and immediately on its assertion, the block SHALL force:
- FSM = IDLE.
- tbl_valid_o = 0.
- req_ready_o = 0.
- rsp_valid_o = 0.
- tbl_ready_o = 0.
- outstanding_o = 0.
- err_o = 0.
- FIFO pointers = 0.
- round-robin pointer to requester 0 first.
REQ-021 Reset asserted mid-transfer SHALL discard any in-flight grant and all queued IDs. Responses that arrive later, after reset is released, SHALL set err_o.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Contention: NUM_REQ=2; both valid continuously; tbl_ready_i=1 -> grants alternate 0,1,0,1; one table transfer every 2 cycles.
- Back-pressure: grant to requester 1; tbl_ready_i=0 for 5 cycles -> tbl_valid_o held 1 and tbl_data_o stable; req_ready_o=00 until tbl_ready_i rises.
- FIFO full: TAG_DEPTH=8; 8 requests accepted, no responses -> outstanding_o=8 and tbl_valid_o stays 0; one response pop -> next grant follows.
- Routing: issue order 1,0,1; three responses 0xA,0xB,0xC -> rsp_valid_o = 10, 01, 10 with matching data; rsp_ready_i[1]=0 stalls via tbl_ready_o=0.
- Spurious response: tbl_valid_i=1 with outstanding_o=0 -> err_o=1 next cycle; rsp_valid_o=00.
- Async reset: assert reset mid-GRANT with outstanding_o=3 -> all outputs reach reset values without a clock edge.
